// File: rtl/mem_line_ctrl.sv
// Line-transfer controller: moves one WORDS-word line between a 32-bit memory port and line buffers.
// Build option CRITICAL_WORD_FIRST_EN: reads start at the requested word instead of word 0.
module mem_line_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Req,
  input  logic                Write,
  input  logic [31:0]         Addr,
  input  logic [32*WORDS-1:0] WLine,
  output logic [32*WORDS-1:0] RLine,
  output logic                Busy,
  output logic                Done,
  output logic                HSEL,
  output logic                re,
  output logic                we,
  output logic [31:0]         a,
  output logic [31:0]         wd,
  input  logic [31:0]         rd,
  input  logic                Valid
);

  localparam int IW = $clog2(WORDS);
  localparam int LW = IW + 2;  // byte-offset bits spanned by one line

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [31:LW]    base_hi;
  logic [IW-1:0]   start_q;
  logic [IW-1:0]   start_d;
  logic [IW-1:0]   count;
  logic [IW-1:0]   idx;
  logic            last;
  logic            start_xfer;
  logic            xfer;
  logic [31:0]     addr_cur;
  logic [31:0]     wbuf [WORDS];
  logic [31:0]     rbuf [WORDS];
  logic            unused_addr_bits;

  assign unused_addr_bits = ^Addr[LW-1:0];

  // Index wraps within the line because idx is exactly log2(WORDS) bits wide.
  assign idx      = start_q + count;
  assign last     = (count == IW'(WORDS - 1));
  assign addr_cur = {base_hi, idx, 2'b00};

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_d = Write ? '0 : Addr[LW-1:2];
`else
  assign start_d = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DONE accepts a pending Req directly so a held request restarts without an idle cycle.
  always_comb begin
    state_d    = state_q;
    start_xfer = 1'b0;
    xfer       = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    HSEL       = 1'b0;
    re         = 1'b0;
    we         = 1'b0;
    a          = '0;
    wd         = '0;
    case (state_q)
      IDLE: begin
        if (Req) begin
          start_xfer = 1'b1;
          state_d    = Write ? WRITE : READ;
        end
      end
      READ: begin
        Busy = 1'b1;
        HSEL = 1'b1;
        re   = 1'b1;
        a    = addr_cur;
        if (Valid) begin
          xfer = 1'b1;
          if (last) state_d = DONE;
        end
      end
      WRITE: begin
        Busy = 1'b1;
        HSEL = 1'b1;
        we   = 1'b1;
        a    = addr_cur;
        wd   = wbuf[idx];
        if (Valid) begin
          xfer = 1'b1;
          if (last) state_d = DONE;
        end
      end
      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
        if (Req) begin
          start_xfer = 1'b1;
          state_d    = Write ? WRITE : READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_hi <= '0;
      start_q <= '0;
      count   <= '0;
      for (int i = 0; i < WORDS; i++) begin
        wbuf[i] <= '0;
        rbuf[i] <= '0;
      end
    end else if (start_xfer) begin
      base_hi <= Addr[31:LW];
      start_q <= start_d;
      count   <= '0;
      for (int i = 0; i < WORDS; i++) begin
        wbuf[i] <= WLine[32*i +: 32];
      end
    end else if (xfer) begin
      count <= count + IW'(1);
      if (re) rbuf[idx] <= rd;
    end
  end

  for (genvar g = 0; g < WORDS; g++) begin : g_rline
    assign RLine[32*g +: 32] = rbuf[g];
  end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Directed bench for mem_line_ctrl (WORDS=4) with a behavioural word memory at byte address A = 0x1000+A.
`timescale 1ns/1ps
module tb_mem_line_ctrl;
  localparam int WORDS = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                Req;
  logic                Write;
  logic [31:0]         Addr;
  logic [32*WORDS-1:0] WLine;
  logic [32*WORDS-1:0] RLine;
  logic                Busy;
  logic                Done;
  logic                HSEL;
  logic                re;
  logic                we;
  logic [31:0]         a;
  logic [31:0]         wd;
  logic [31:0]         rd;
  logic                Valid;

  logic [31:0] mem [256];
  int n_checks = 0;
  int n_fail   = 0;

  mem_line_ctrl #(.WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .Req(Req), .Write(Write), .Addr(Addr),
    .WLine(WLine), .RLine(RLine), .Busy(Busy), .Done(Done), .HSEL(HSEL),
    .re(re), .we(we), .a(a), .wd(wd), .rd(rd), .Valid(Valid)
  );

  always #5 clk = ~clk;

  assign rd = mem[a[9:2]];
  always @(posedge clk) if (we && Valid) mem[a[9:2]] <= wd;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0]  rd_a  [4];
  logic [31:0]  rd_a2 [4];
  logic [127:0] line_exp;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + 32'(4 * i);
`ifdef CRITICAL_WORD_FIRST_EN
    rd_a  = '{32'h104, 32'h108, 32'h10C, 32'h100};
    rd_a2 = '{32'h108, 32'h10C, 32'h100, 32'h104};
`else
    rd_a  = '{32'h100, 32'h104, 32'h108, 32'h10C};
    rd_a2 = '{32'h100, 32'h104, 32'h108, 32'h10C};
`endif
    line_exp = {32'h110C, 32'h1108, 32'h1104, 32'h1100};

    reset = 1'b1; Req = 1'b0; Write = 1'b0; Addr = '0; WLine = '0; Valid = 1'b0;
    #12;
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_hsel", {HSEL, re, we}, 3'b000);
    check("rst_a", a, 32'h0);
    check("rst_wd", wd, 32'h0);
    check("rst_rline", RLine, 128'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    step();

    // Line read, Valid always high
    Req = 1'b1; Write = 1'b0; Addr = 32'h104; Valid = 1'b1;
    step();
    Req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rd_ctl", {Busy, HSEL, re, we, Done}, 5'b11100);
      check($sformatf("rd_a%0d", i), a, rd_a[i]);
      step();
    end
    check("rd_done", {Done, Busy, HSEL, re, we}, 5'b10000);
    check("rd_done_a", a, 32'h0);
    check("rd_rline", RLine, line_exp);
    step();
    check("rd_after", {Done, Busy}, 2'b00);
    check("rd_rline_hold", RLine, line_exp);

    // Line write with two wait states on the second word
    Req = 1'b1; Write = 1'b1; Addr = 32'h20;
    WLine = {32'hA3, 32'hA2, 32'hA1, 32'hA0}; Valid = 1'b1;
    step();
    Req = 1'b0;
    check("wr_c1_ctl", {Busy, HSEL, re, we, Done}, 5'b11010);
    check("wr_c1_a", a, 32'h20);
    check("wr_c1_wd", wd, 32'hA0);
    step();
    Valid = 1'b0;
    check("wr_c2_a", a, 32'h24);
    check("wr_c2_wd", wd, 32'hA1);
    step();
    check("wr_c3_a", a, 32'h24);
    check("wr_c3_wd", wd, 32'hA1);
    check("wr_c3_done", Done, 1'b0);
    step();
    Valid = 1'b1;
    check("wr_c4_a", a, 32'h24);
    check("wr_c4_wd", wd, 32'hA1);
    step();
    check("wr_c5_a", a, 32'h28);
    check("wr_c5_wd", wd, 32'hA2);
    step();
    check("wr_c6_a", a, 32'h2C);
    check("wr_c6_wd", wd, 32'hA3);
    check("wr_c6_done", Done, 1'b0);
    step();
    check("wr_c7_done", {Done, Busy, HSEL, we}, 4'b1000);
    check("wr_c7_wd", wd, 32'h0);
    check("wr_mem", {mem[11], mem[10], mem[9], mem[8]}, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    check("wr_rline_kept", RLine, line_exp);
    step();
    check("wr_after", {Done, Busy}, 2'b00);

    // Reset in the middle of a read, after two words
    Req = 1'b1; Write = 1'b0; Addr = 32'h100;
    step();
    Req = 1'b0;
    step();
    step();
    check("mr_busy", {Busy, HSEL, re}, 3'b111);
    #3;
    reset = 1'b1;
    #1;
    check("mr_async_ctl", {Busy, HSEL, re, we, Done}, 5'b00000);
    check("mr_async_a", a, 32'h0);
    check("mr_rline", RLine, 128'h0);
    step();
    step();
    check("mr_hold_done", {Done, HSEL}, 2'b00);
    reset = 1'b0;
    step();
    check("mr_idle", {Busy, HSEL, Done}, 3'b000);
    Req = 1'b1; Write = 1'b0; Addr = 32'h108;
    step();
    Req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("mr2_done_low", Done, 1'b0);
      check($sformatf("mr2_a%0d", i), a, rd_a2[i]);
      step();
    end
    check("mr2_done", Done, 1'b1);
    check("mr2_rline", RLine, line_exp);
    step();

    // Req held across Done, then Req pulses while busy
    Req = 1'b1; Write = 1'b0; Addr = 32'h100;
    step();
    for (int i = 0; i < 4; i++) begin
      check("rh_busy", Busy, 1'b1);
      step();
    end
    check("rh_done", {Done, Busy}, 2'b10);
    step();
    check("rh_restart", {Busy, HSEL, re, Done}, 4'b1110);
    check("rh_restart_a", a, 32'h100);
    Req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) Req = 1'b1;
      if (i == 2) Req = 1'b0;
      check("rh2_busy", Busy, 1'b1);
      step();
    end
    check("rh2_done", {Done, Busy}, 2'b10);
    step();
    check("rh_idle1", {Busy, HSEL, Done}, 3'b000);
    step();
    check("rh_idle2", {Busy, HSEL, Done}, 3'b000);
    check("rh_rline", RLine, line_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
